decode_stage: RTL and testbench

RV32I instruction decode stage sitting directly upstream of `register_file`. Accepts fetched instructions over a valid/ready handshake, drives the register file read addresses, and generates immediates and control fields. A per-register busy scoreboard stalls on RAW/WAW hazards. Each decoded instruction and its operands are held in an output pipeline register toward execute.

---
 rtl/rv_pkg.sv | 80 ++++++++
 rtl/decode_stage_if.sv | 30 +++
 rtl/imm_gen.sv | 22 ++
 rtl/decode_stage.sv | 104 ++++++++++
 tb/tb_decode_stage.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// RV32I decode definitions shared by the decode stage, its immediate generator and the execute bus.
package rv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned OPC_W    = 7;

    localparam logic [OPC_W-1:0] OP_LUI      = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC    = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL      = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_JALR     = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_BRANCH   = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LOAD     = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE    = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_IMM      = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_OP       = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [OPC_W-1:0] OP_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_t;

    typedef struct packed {
        imm_fmt_t imm_fmt;
        logic     uses_rs1;
        logic     uses_rs2;
        logic     writes_rd;  // class writes rd; rd==x0 is filtered later
        logic     illegal;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [OPC_W-1:0] opcode);
        ctrl_t c;
        c = '{imm_fmt: IMM_NONE, uses_rs1: 1'b0, uses_rs2: 1'b0, writes_rd: 1'b0, illegal: 1'b0};
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                c.imm_fmt   = IMM_U;
                c.writes_rd = 1'b1;
            end
            OP_JAL: begin
                c.imm_fmt   = IMM_J;
                c.writes_rd = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                c.imm_fmt   = IMM_I;
                c.uses_rs1  = 1'b1;
                c.writes_rd = 1'b1;
            end
            OP_BRANCH: begin
                c.imm_fmt  = IMM_B;
                c.uses_rs1 = 1'b1;
                c.uses_rs2 = 1'b1;
            end
            OP_STORE: begin
                c.imm_fmt  = IMM_S;
                c.uses_rs1 = 1'b1;
                c.uses_rs2 = 1'b1;
            end
            OP_OP: begin
                c.uses_rs1  = 1'b1;
                c.uses_rs2  = 1'b1;
                c.writes_rd = 1'b1;
            end
            OP_MISC_MEM, OP_SYSTEM: begin
                c.imm_fmt = IMM_I;
            end
            default: begin
                c.illegal = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode-to-execute bus: registered decoded instruction plus valid/ready handshake.
interface decode_if;
    import rv_pkg::*;

    logic                ex_valid;
    logic                ex_ready;
    logic [XLEN-1:0]     ex_pc;
    logic [XLEN-1:0]     ex_rs1_data;
    logic [XLEN-1:0]     ex_rs2_data;
    logic [XLEN-1:0]     ex_imm;
    logic [REG_AW-1:0]   ex_rd;
    logic [OPC_W-1:0]    ex_opcode;
    logic [2:0]          ex_funct3;
    logic                ex_funct7b5;
    logic                ex_writes_rd;
    logic                ex_illegal;

    modport master (
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
               ex_opcode, ex_funct3, ex_funct7b5, ex_writes_rd, ex_illegal,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
               ex_opcode, ex_funct3, ex_funct7b5, ex_writes_rd, ex_illegal,
        output ex_ready
    );

endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction; all formats sign-extend from instr[31].
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:7]     instr,
    input  imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register-file addressing, immediate/control decode, busy-bit
// hazard scoreboard and a registered handoff to execute.
module decode_stage
    import rv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [XLEN-1:0]   if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              id_ready,
    output logic [REG_AW-1:0] source1,
    output logic [REG_AW-1:0] source2,
    input  logic [XLEN-1:0]   read_data1,
    input  logic [XLEN-1:0]   read_data2,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic              flush,
    decode_if.master          ex
);

    ctrl_t             ctrl;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0]   imm;
    logic              in_writes_rd;
    logic              ex_pending;
    logic              hit_rs1, hit_rs2, hit_rd;
    logic              hazard;
    logic              accept;
    logic              handoff;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    assign ctrl         = decode_ctrl(if_instr[6:0]);
    assign rs1          = if_instr[19:15];
    assign rs2          = if_instr[24:20];
    assign rd           = if_instr[11:7];
    assign in_writes_rd = ctrl.writes_rd && (rd != '0);

    assign source1 = ctrl.uses_rs1 ? rs1 : '0;
    assign source2 = ctrl.uses_rs2 ? rs2 : '0;

    imm_gen u_imm_gen (
        .instr (if_instr[31:7]),
        .fmt   (ctrl.imm_fmt),
        .imm   (imm)
    );

    // A register is unavailable if it is busy or about to be claimed by the held instruction.
    assign ex_pending = ex.ex_valid && ex.ex_writes_rd;
    assign hit_rs1 = ctrl.uses_rs1 && (rs1 != '0) && (busy_q[rs1] || (ex_pending && (ex.ex_rd == rs1)));
    assign hit_rs2 = ctrl.uses_rs2 && (rs2 != '0) && (busy_q[rs2] || (ex_pending && (ex.ex_rd == rs2)));
    assign hit_rd  = in_writes_rd && (busy_q[rd] || (ex_pending && (ex.ex_rd == rd)));
    assign hazard  = if_valid && (hit_rs1 || hit_rs2 || hit_rd);

    assign id_ready = !flush && !hazard && (!ex.ex_valid || ex.ex_ready);
    assign accept   = if_valid && id_ready;
    assign handoff  = ex.ex_valid && ex.ex_ready && ex.ex_writes_rd && !flush;

    // Clear first so a same-index set wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid && (wb_dest != '0)) begin
            busy_d[wb_dest] = 1'b0;
        end
        if (handoff) begin
            busy_d[ex.ex_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q          <= '0;
            ex.ex_valid     <= 1'b0;
            ex.ex_pc        <= '0;
            ex.ex_rs1_data  <= '0;
            ex.ex_rs2_data  <= '0;
            ex.ex_imm       <= '0;
            ex.ex_rd        <= '0;
            ex.ex_opcode    <= '0;
            ex.ex_funct3    <= '0;
            ex.ex_funct7b5  <= 1'b0;
            ex.ex_writes_rd <= 1'b0;
            ex.ex_illegal   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (accept) begin
                ex.ex_valid     <= 1'b1;
                ex.ex_pc        <= if_pc;
                ex.ex_rs1_data  <= read_data1;
                ex.ex_rs2_data  <= read_data2;
                ex.ex_imm       <= imm;
                ex.ex_rd        <= rd;
                ex.ex_opcode    <= if_instr[6:0];
                ex.ex_funct3    <= if_instr[14:12];
                ex.ex_funct7b5  <= if_instr[30];
                ex.ex_writes_rd <= in_writes_rd;
                ex.ex_illegal   <= ctrl.illegal;
            end else if (ex.ex_ready || flush) begin
                ex.ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected decodes are queued on accept and
// compared when the execute handshake completes.
module tb_decode_stage;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic [4:0]  source1, source2;
    logic [31:0] read_data1, read_data2;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic        flush;

    decode_if ex_bus();

    decode_stage dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_ready   (id_ready),
        .source1    (source1),
        .source2    (source2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .wb_valid   (wb_valid),
        .wb_dest    (wb_dest),
        .flush      (flush),
        .ex         (ex_bus)
    );

    always #5 clk = ~clk;

    logic [31:0] reg_val [32];
    assign read_data1 = (source1 == 5'd0) ? 32'd0 : reg_val[source1];
    assign read_data2 = (source2 == 5'd0) ? 32'd0 : reg_val[source2];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        writes_rd;
        logic        illegal;
        logic [4:0]  src1;
        logic [4:0]  src2;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Independent reference decode: class table plus arithmetic-shift sign extension.
    function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
        exp_t        e;
        logic        u1, u2, wr;
        logic [31:0] raw;
        logic [6:0]  op;
        op  = instr[6:0];
        u1  = 1'b0; u2 = 1'b0; wr = 1'b0;
        e.illegal = 1'b0;
        e.imm     = 32'd0;
        case (op)
            7'h37, 7'h17: begin wr = 1'b1; e.imm = {instr[31:12], 12'h000}; end
            7'h6F: begin
                wr = 1'b1;
                raw = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0, 11'd0};
                e.imm = 32'($signed(raw) >>> 11);
            end
            7'h67, 7'h03, 7'h13: begin u1 = 1'b1; wr = 1'b1; e.imm = 32'($signed(instr) >>> 20); end
            7'h63: begin
                u1 = 1'b1; u2 = 1'b1;
                raw = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0, 19'd0};
                e.imm = 32'($signed(raw) >>> 19);
            end
            7'h23: begin
                u1 = 1'b1; u2 = 1'b1;
                raw = {instr[31:25], instr[11:7], 20'd0};
                e.imm = 32'($signed(raw) >>> 20);
            end
            7'h33: begin u1 = 1'b1; u2 = 1'b1; wr = 1'b1; end
            7'h0F, 7'h73: e.imm = 32'($signed(instr) >>> 20);
            default: e.illegal = 1'b1;
        endcase
        e.src1      = u1 ? instr[19:15] : 5'd0;
        e.src2      = u2 ? instr[24:20] : 5'd0;
        e.rs1_data  = (e.src1 == 5'd0) ? 32'd0 : reg_val[e.src1];
        e.rs2_data  = (e.src2 == 5'd0) ? 32'd0 : reg_val[e.src2];
        e.pc        = pc;
        e.rd        = instr[11:7];
        e.opcode    = op;
        e.funct3    = instr[14:12];
        e.funct7b5  = instr[30];
        e.writes_rd = wr && (instr[11:7] != 5'd0);
        return e;
    endfunction

    // One cycle of stimulus; expected id_ready is given explicitly per step.
    task automatic step(input logic v, input logic [31:0] instr, input logic er, input logic fl,
                        input logic wbv, input logic [4:0] wbd, input logic exp_rdy);
        exp_t e;
        if_valid        = v;
        if_instr        = instr;
        if_pc           = pc_ctr;
        ex_bus.ex_ready = er;
        flush           = fl;
        wb_valid        = wbv;
        wb_dest         = wbd;
        #2;
        check_eq("id_ready", 32'(id_ready), 32'(exp_rdy));
        if (v) begin
            e = ref_decode(instr, pc_ctr);
            check_eq("source1", 32'(source1), 32'(e.src1));
            check_eq("source2", 32'(source2), 32'(e.src2));
            if (exp_rdy) begin
                sb.push_back(e);
                pc_ctr = pc_ctr + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        if (wbv && wbd != 5'd0) reg_val[wbd] = reg_val[wbd] ^ 32'hA5A5_0000;
    endtask

    // Handoff monitor: pops on completion; a flushed entry is discarded unchecked.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ex_bus.ex_valid && (ex_bus.ex_ready || flush)) begin
            if (sb.size() == 0) begin
                check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                if (!flush) begin
                    check_eq("ex_pc",        ex_bus.ex_pc,              e.pc);
                    check_eq("ex_rs1_data",  ex_bus.ex_rs1_data,        e.rs1_data);
                    check_eq("ex_rs2_data",  ex_bus.ex_rs2_data,        e.rs2_data);
                    check_eq("ex_imm",       ex_bus.ex_imm,             e.imm);
                    check_eq("ex_rd",        32'(ex_bus.ex_rd),         32'(e.rd));
                    check_eq("ex_opcode",    32'(ex_bus.ex_opcode),     32'(e.opcode));
                    check_eq("ex_funct3",    32'(ex_bus.ex_funct3),     32'(e.funct3));
                    check_eq("ex_funct7b5",  32'(ex_bus.ex_funct7b5),   32'(e.funct7b5));
                    check_eq("ex_writes_rd", 32'(ex_bus.ex_writes_rd),  32'(e.writes_rd));
                    check_eq("ex_illegal",   32'(ex_bus.ex_illegal),    32'(e.illegal));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) reg_val[i] = 32'h1000_0000 + 32'(i);
        rst = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
        wb_valid = 1'b0; wb_dest = 5'd0; flush = 1'b0; ex_bus.ex_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ex_valid",     32'(ex_bus.ex_valid),     32'd0);
        check_eq("rst_ex_pc",        ex_bus.ex_pc,             32'd0);
        check_eq("rst_ex_imm",       ex_bus.ex_imm,            32'd0);
        check_eq("rst_ex_rd",        32'(ex_bus.ex_rd),        32'd0);
        check_eq("rst_ex_writes_rd", 32'(ex_bus.ex_writes_rd), 32'd0);
        check_eq("rst_ex_illegal",   32'(ex_bus.ex_illegal),   32'd0);
        rst = 1'b0;

        // ADDI x5,x0,7 then ADD x6,x5,x5: RAW stall until writeback of x5, then accept.
        step(1'b1, 32'h0070_0293, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        step(1'b1, 32'h0052_8333, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, 32'h0052_8333, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b1, 32'h0052_8333, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
        step(1'b1, 32'h0052_8333, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);

        // SW x5,-4(x2), then hold it three cycles behind ex_ready=0.
        step(1'b1, 32'hFE51_2E23, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h1234_53B7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
            check_eq("hold_valid", 32'(ex_bus.ex_valid), 32'd1);
            check_eq("hold_imm",   ex_bus.ex_imm,        32'hFFFF_FFFC);
            check_eq("hold_rs2",   ex_bus.ex_rs2_data,   reg_val[5]);
        end
        step(1'b1, 32'h1234_53B7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);

        // Flush a held x9 writer; x9 must not become busy.
        step(1'b1, 32'h0010_0493, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        step(1'b1, 32'h0020_0513, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
        check_eq("flush_valid", 32'(ex_bus.ex_valid), 32'd0);
        step(1'b1, 32'h0094_85B3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);

        // Illegal opcode with rd=x12 neither writes nor stalls a reader of x12.
        step(1'b1, 32'h0000_067F, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        step(1'b1, 32'h0016_0693, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);

        // ADDI x0, BEQ, JAL x0, AUIPC: immediate formats at full throughput.
        step(1'b1, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        step(1'b1, 32'hFE00_0CE3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        step(1'b1, 32'h8000_006F, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        step(1'b1, 32'hFFFF_F817, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);

        // WAW on x13 (written by the earlier ADDI x13,x12,1) until its writeback.
        step(1'b1, 32'h0050_0693, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0);
        step(1'b1, 32'h0050_0693, 1'b1, 1'b0, 1'b1, 5'd13, 1'b0);
        step(1'b1, 32'h0050_0693, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1);

        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
